alu_muldiv: RTL and testbench

Parametrised multi-cycle successor to the 32-bit combinational MIPS ALU. It keeps the R-type funct encoding on Signal and computes AND/OR/ADD/SUB/SLT in one cycle. It adds iterative unsigned multiply and divide into internal HI/LO registers, plus MFHI/MFLO read-back. It sits in the EX stage of the multi-cycle MIPS datapath behind a start/busy/done handshake.

---
 rtl/alu_muldiv_if.sv | 22 ++
 rtl/alu_muldiv.sv | 135 +++++++++++++
 tb/tb_alu_muldiv.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Handshake and operand bus between the EX-stage controller (master) and alu_muldiv (slave).
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] dataOut;
    logic             busy;
    logic             done;

    modport master (
        output start, Signal, dataA, dataB,
        input  dataOut, busy, done
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output dataOut, busy, done
    );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS EX-stage ALU: single-cycle logic/arith ops plus iterative unsigned MULTU/DIVU
// into internal HI/LO registers, behind a start/busy/done handshake.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_cnt;
    logic                 r_is_div;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_dout;

    logic                 w_accept;
    logic                 w_is_long;
    logic                 w_last_iter;
    logic [WIDTH-1:0]     w_alu;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_iter_next;

    assign w_accept    = (r_state != S_RUN) && bus.start;
    assign w_is_long   = (bus.Signal == F_MULTU) || (bus.Signal == F_DIVU);
    assign w_last_iter = (r_cnt == CW'(1));

    // Multiply: r_acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: r_acc = {remainder, dividend bits becoming quotient bits}, shifted left each step.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_iter_next = r_is_div ? w_div_next : w_mul_next;

    always_comb begin
        w_alu = '0;
        unique case (bus.Signal)
            F_AND:   w_alu = bus.dataA & bus.dataB;
            F_OR:    w_alu = bus.dataA | bus.dataB;
            F_ADD:   w_alu = bus.dataA + bus.dataB;
            F_SUB:   w_alu = bus.dataA - bus.dataB;
            F_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
            F_MFHI:  w_alu = r_hi;
            F_MFLO:  w_alu = r_lo;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        unique case (r_state)
            S_RUN:   w_state_next = w_last_iter ? S_DONE : S_RUN;
            default: begin
                if (w_accept) begin
                    w_state_next = w_is_long ? S_RUN : S_DONE;
                end
            end
        endcase
    end

    always_comb begin
        bus.busy    = (r_state == S_RUN);
        bus.done    = (r_state == S_DONE);
        bus.dataOut = r_dout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dout   <= '0;
        end else if (w_accept) begin
            if (w_is_long) begin
                r_is_div <= (bus.Signal == F_DIVU);
                r_cnt    <= CW'(WIDTH);
                if (bus.Signal == F_DIVU) begin
                    r_opnd <= bus.dataB;
                    r_acc  <= {{WIDTH{1'b0}}, bus.dataA};
                end else begin
                    r_opnd <= bus.dataA;
                    r_acc  <= {{WIDTH{1'b0}}, bus.dataB};
                end
            end else begin
                r_dout <= w_alu;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= w_iter_next;
            r_cnt <= r_cnt - CW'(1);
            if (w_last_iter) begin
                r_hi   <= w_iter_next[2*WIDTH-1:WIDTH];
                r_lo   <= w_iter_next[WIDTH-1:0];
                r_dout <= w_iter_next[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_muldiv;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(32)) bus32();
    alu_muldiv_if #(.WIDTH(8))  bus8();

    alu_muldiv #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_muldiv #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic st, input logic [5:0] sig,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start = st; bus8.Signal = sig; bus8.dataA = a[7:0]; bus8.dataB = b[7:0];
        end else begin
            bus32.start = st; bus32.Signal = sig; bus32.dataA = a; bus32.dataB = b;
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, optionally poke an ADD
    // start at cycle 'poke' while running, and check latency, busy length and result.
    task automatic op(input string tag, input bit w8, input bit b2b, input logic [5:0] sig,
                      input logic [31:0] a, input logic [31:0] b, input int poke,
                      input int lat_exp, input logic [31:0] exp);
        int          lat;
        int          busy_n;
        logic [31:0] dout;
        if (!b2b) @(negedge clk);
        drive(w8, 1'b1, sig, a, b);
        @(posedge clk); #1;
        drive(w8, 1'b0, ~sig, ~a, ~b);
        lat = 0;
        busy_n = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (poke != 0 && lat == poke) drive(w8, 1'b1, F_ADD, a, b);
            else if (poke != 0 && lat == poke + 1) drive(w8, 1'b0, F_ADD, a, b);
            if (w8 ? bus8.done : bus32.done) break;
            if (w8 ? bus8.busy : bus32.busy) busy_n++;
        end
        dout = w8 ? {24'b0, bus8.dataOut} : bus32.dataOut;
        $display("%s: W=%0d sig=%b a=0x%h b=0x%h -> dataOut=0x%h latency=%0d busy=%0d",
                 tag, w8 ? 8 : 32, sig, a, b, dout, lat, busy_n);
        chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, " busy"},    64'(busy_n), 64'(lat_exp - 1));
        chk({tag, " dataOut"}, {32'b0, dout}, {32'b0, exp});
    endtask

    initial begin
        drive(1'b0, 1'b0, 6'b0, 32'b0, 32'b0);
        drive(1'b1, 1'b0, 6'b0, 32'b0, 32'b0);
        repeat (3) @(negedge clk);
        $display("reset: dataOut=0x%h busy=%b done=%b", bus32.dataOut, bus32.busy, bus32.done);
        chk("rst dataOut32", {32'b0, bus32.dataOut}, 64'h0);
        chk("rst busy32",    {63'b0, bus32.busy},    64'h0);
        chk("rst done32",    {63'b0, bus32.done},    64'h0);
        chk("rst dataOut8",  {56'b0, bus8.dataOut},  64'h0);
        reset = 1'b1;

        op("ADD",    1'b0, 1'b0, F_ADD,   32'h7FFFFFFF, 32'h00000001, 0, 1, 32'h80000000);
        op("SUB",    1'b0, 1'b0, F_SUB,   32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF);
        op("UNK",    1'b0, 1'b0, 6'b111111, 32'h12345678, 32'h9ABCDEF0, 0, 1, 32'h00000000);
        op("AND",    1'b0, 1'b0, F_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 0, 1, 32'h00F000F0);
        op("OR",     1'b0, 1'b0, F_OR,    32'hF0F0F0F0, 32'h0FF00FF0, 0, 1, 32'hFFF0FFF0);
        op("SLT1",   1'b0, 1'b0, F_SLT,   32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000001);
        op("SLT0",   1'b0, 1'b0, F_SLT,   32'h7FFFFFFF, 32'h80000000, 0, 1, 32'h00000000);

        op("MULTU",  1'b0, 1'b0, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 32'h00000001);
        op("MFHI1",  1'b0, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'hFFFFFFFE);
        op("MFLO1",  1'b0, 1'b0, F_MFLO,  32'h0, 32'h0, 0, 1, 32'h00000001);

        op("DIVU",   1'b0, 1'b0, F_DIVU,  32'd100, 32'd7, 0, 33, 32'd14);
        op("ADDb2b", 1'b0, 1'b1, F_ADD,   32'd2, 32'd3, 0, 1, 32'd5);
        op("MFHI2",  1'b0, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'd2);
        op("MFLO2",  1'b0, 1'b0, F_MFLO,  32'h0, 32'h0, 0, 1, 32'd14);

        op("DIVU0",  1'b0, 1'b0, F_DIVU,  32'd5, 32'd0, 0, 33, 32'hFFFFFFFF);
        op("MFHI3",  1'b0, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'd5);

        op("MULpoke", 1'b0, 1'b0, F_MULTU, 32'd3, 32'd5, 5, 33, 32'd15);
        op("MFHI4",  1'b0, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'd0);
        op("MFLO4",  1'b0, 1'b0, F_MFLO,  32'h0, 32'h0, 0, 1, 32'd15);

        // Reset in the middle of a long multiply.
        @(negedge clk);
        drive(1'b0, 1'b1, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, F_ADD, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        chk("pre-reset busy", {63'b0, bus32.busy}, 64'h1);
        reset = 1'b0;
        #1;
        $display("mid-run reset: dataOut=0x%h busy=%b done=%b", bus32.dataOut, bus32.busy, bus32.done);
        chk("mrst dataOut", {32'b0, bus32.dataOut}, 64'h0);
        chk("mrst busy",    {63'b0, bus32.busy},    64'h0);
        chk("mrst done",    {63'b0, bus32.done},    64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post-reset done", {63'b0, bus32.done}, 64'h0);
        chk("post-reset busy", {63'b0, bus32.busy}, 64'h0);

        op("MFHIr",  1'b0, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'd0);
        op("DIVU92", 1'b0, 1'b0, F_DIVU,  32'd9, 32'd2, 0, 33, 32'd4);
        op("MFHI5",  1'b0, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'd1);

        op("MULTU8", 1'b1, 1'b0, F_MULTU, 32'hFF, 32'hFF, 0, 9, 32'h01);
        op("MFHI8",  1'b1, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'hFE);
        op("DIVU8",  1'b1, 1'b0, F_DIVU,  32'd100, 32'd7, 0, 9, 32'd14);
        op("MFHI8b", 1'b1, 1'b0, F_MFHI,  32'h0, 32'h0, 0, 1, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
